// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared encodings and constants for the instruction fetch stage
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_REQ  = 2'd1,
    S_KILL = 2'd2,
    S_WAIT = 2'd3
  } fetch_state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [31:0] BUBBLE_WORD = 32'h0000_0000;

  localparam int IMM16_MSB    = 15;
  localparam int TARGET26_MSB = 25;

endpackage

// File: rtl/instr_fetch_target.sv
// rtl/instr_fetch_target.sv - branch and jump target computation from the IF/ID instruction and its PC+4
module instr_fetch_target
  import instr_fetch_pkg::*;
(
  input  logic [TARGET26_MSB:0] instr_field_i,
  input  logic [31:0]           pc4_i,
  output logic [31:0]           branch_target_o,
  output logic [31:0]           jump_target_o
);

  logic [IMM16_MSB:0] imm;

  assign imm = instr_field_i[IMM16_MSB:0];

  // Word offset, sign-extended; the add wraps at 32 bits.
  assign branch_target_o = pc4_i + {{14{imm[IMM16_MSB]}}, imm, 2'b00};
  assign jump_target_o   = {pc4_i[31:28], instr_field_i, 2'b00};

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - PC, imem req/ack FSM, one-entry skid and IF/ID register
// Define IF_DELAY_SLOT_EN to keep the word fetched behind a redirect (delay slot) instead of flushing it.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] BUBBLE   = BUBBLE_WORD
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  input  logic        stall_i,
  input  logic        branch_i,
  input  logic        jump_i,
  output logic        ifid_valid_o,
  output logic [31:0] ifid_instr_o,
  output logic [31:0] ifid_pc4_o,
  output logic [31:0] pc_o
);

  fetch_state_e state_q;
  logic [31:0]  pc_q, kill_addr_q, skid_instr_q, skid_pc4_q;
  logic [31:0]  ifid_instr_q, ifid_pc4_q;
  logic         ifid_valid_q;

  logic         redirect, req;
  logic [31:0]  addr, pc_plus4, branch_target, jump_target, target;

  instr_fetch_target u_target (
    .instr_field_i   (ifid_instr_q[TARGET26_MSB:0]),
    .pc4_i           (ifid_pc4_q),
    .branch_target_o (branch_target),
    .jump_target_o   (jump_target)
  );

  assign redirect = (branch_i | jump_i) & ifid_valid_q;
  assign target   = jump_i ? jump_target : branch_target;
  assign req      = (state_q == S_REQ) || (state_q == S_KILL);
  // The killed request keeps its original address until memory answers it.
  assign addr     = (state_q == S_KILL) ? kill_addr_q : pc_q;
  assign pc_plus4 = pc_q + 32'd4;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_BOOT;
      pc_q         <= RESET_PC;
      kill_addr_q  <= RESET_PC;
      skid_instr_q <= BUBBLE;
      skid_pc4_q   <= '0;
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= BUBBLE;
      ifid_pc4_q   <= '0;
    end else if (redirect) begin
      pc_q <= target;
`ifdef IF_DELAY_SLOT_EN
      if (state_q == S_REQ && imem_ack_i) begin
        ifid_valid_q <= 1'b1;
        ifid_instr_q <= imem_data_i;
        ifid_pc4_q   <= pc_plus4;
        state_q      <= S_REQ;
      end else if (state_q == S_WAIT) begin
        ifid_valid_q <= 1'b1;
        ifid_instr_q <= skid_instr_q;
        ifid_pc4_q   <= skid_pc4_q;
        state_q      <= S_REQ;
      end else begin
        ifid_valid_q <= 1'b0;
        ifid_instr_q <= BUBBLE;
        if (req) begin
          kill_addr_q <= addr;
          state_q     <= S_KILL;
        end else begin
          state_q <= S_REQ;
        end
      end
`else
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= BUBBLE;
      if (req && !imem_ack_i) begin
        kill_addr_q <= addr;
        state_q     <= S_KILL;
      end else begin
        state_q <= S_REQ;
      end
`endif
    end else begin
      case (state_q)
        S_BOOT: begin
          state_q <= S_REQ;
          if (!stall_i) begin
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= BUBBLE;
          end
        end
        S_REQ: begin
          if (imem_ack_i) begin
            pc_q <= pc_plus4;
            if (stall_i) begin
              skid_instr_q <= imem_data_i;
              skid_pc4_q   <= pc_plus4;
              state_q      <= S_WAIT;
            end else begin
              ifid_valid_q <= 1'b1;
              ifid_instr_q <= imem_data_i;
              ifid_pc4_q   <= pc_plus4;
            end
          end else if (!stall_i) begin
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= BUBBLE;
          end
        end
        S_KILL: begin
`ifdef IF_DELAY_SLOT_EN
          // The PC already holds the target; the delay-slot word carries its own PC+4.
          if (imem_ack_i) begin
            if (stall_i) begin
              skid_instr_q <= imem_data_i;
              skid_pc4_q   <= kill_addr_q + 32'd4;
              state_q      <= S_WAIT;
            end else begin
              ifid_valid_q <= 1'b1;
              ifid_instr_q <= imem_data_i;
              ifid_pc4_q   <= kill_addr_q + 32'd4;
              state_q      <= S_REQ;
            end
          end else if (!stall_i) begin
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= BUBBLE;
          end
`else
          if (imem_ack_i) begin
            state_q <= S_REQ;
          end
          if (!stall_i) begin
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= BUBBLE;
          end
`endif
        end
        S_WAIT: begin
          if (!stall_i) begin
            ifid_valid_q <= 1'b1;
            ifid_instr_q <= skid_instr_q;
            ifid_pc4_q   <= skid_pc4_q;
            state_q      <= S_REQ;
          end
        end
        default: state_q <= S_BOOT;
      endcase
    end
  end

  assign imem_req_o   = req;
  assign imem_addr_o  = addr;
  assign ifid_valid_o = ifid_valid_q;
  assign ifid_instr_o = ifid_instr_q;
  assign ifid_pc4_o   = ifid_pc4_q;
  assign pc_o         = pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch with a reference model and directed vectors
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_data_i = '0;
  logic        stall_i = 1'b0;
  logic        branch_i = 1'b0;
  logic        jump_i = 1'b0;
  logic        imem_req_o, ifid_valid_o;
  logic [31:0] imem_addr_o, ifid_instr_o, ifid_pc4_o, pc_o;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  instr_fetch dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_ack_i   (imem_ack_i),
    .imem_data_i  (imem_data_i),
    .stall_i      (stall_i),
    .branch_i     (branch_i),
    .jump_i       (jump_i),
    .ifid_valid_o (ifid_valid_o),
    .ifid_instr_o (ifid_instr_o),
    .ifid_pc4_o   (ifid_pc4_o),
    .pc_o         (pc_o)
  );

  logic [25:0] t_field;
  logic [31:0] t_pc4, t_br, t_j;

  instr_fetch_target u_tgt (
    .instr_field_i   (t_field),
    .pc4_i           (t_pc4),
    .branch_target_o (t_br),
    .jump_target_o   (t_j)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction memory: ack once a request has been up for lat full cycles.
  logic [31:0] mem [logic [31:0]];
  int   lat = 1;
  int   age = 0;
  logic req_seen = 1'b0;

  function automatic logic [31:0] rd(input logic [31:0] a);
    logic [15:0] lo;
    lo = a[15:0];
    return mem.exists(a) ? mem[a] : {16'hC0DE, lo};
  endfunction

  initial forever begin
    @(negedge clk_i);
    req_seen = imem_req_o;
  end

  initial forever begin
    @(posedge clk_i);
    #1;
    if (rst_i || imem_ack_i) begin
      imem_ack_i = 1'b0;
      age = 0;
    end else begin
      if (req_seen) age++;
      if (imem_req_o && age >= lat) begin
        imem_ack_i  = 1'b1;
        imem_data_i = rd(imem_addr_o);
      end
    end
  end

  // Reference model: fetch program flow tracked as PC, IF/ID slot, skid queue and a kill flag.
  logic [31:0] m_pc, m_instr, m_pc4, m_kaddr, m_tgt;
  logic        m_valid, m_boot, m_kill, m_ready = 1'b0, m_req;
  logic [63:0] skid[$];
  logic [63:0] m_e;

  initial forever begin
    @(posedge clk_i or posedge rst_i);
    if (rst_i) begin
      m_pc = 32'h0; m_valid = 1'b0; m_instr = BUBBLE_WORD; m_pc4 = 32'h0;
      m_boot = 1'b1; m_kill = 1'b0; m_kaddr = 32'h0; skid.delete(); m_ready = 1'b1;
    end else begin
      m_req = !m_boot && skid.size() == 0;
      if ((branch_i || jump_i) && m_valid) begin
        if (jump_i) m_tgt = {m_pc4[31:28], m_instr[25:0], 2'b00};
        else        m_tgt = m_pc4 + 32'(int'($signed(m_instr[15:0])) * 4);
        if (m_req && !imem_ack_i) begin
          if (!m_kill) m_kaddr = m_pc;
          m_kill = 1'b1;
        end else begin
          m_kill = 1'b0;
        end
        m_pc = m_tgt; m_valid = 1'b0; m_instr = BUBBLE_WORD; skid.delete();
      end else if (m_boot) begin
        m_boot = 1'b0;
        if (!stall_i) begin m_valid = 1'b0; m_instr = BUBBLE_WORD; end
      end else if (skid.size() != 0) begin
        if (!stall_i) begin
          m_e = skid.pop_front();
          m_valid = 1'b1; m_instr = m_e[63:32]; m_pc4 = m_e[31:0];
        end
      end else if (imem_ack_i && m_kill) begin
        m_kill = 1'b0;
        if (!stall_i) begin m_valid = 1'b0; m_instr = BUBBLE_WORD; end
      end else if (imem_ack_i) begin
        if (stall_i) skid.push_back({imem_data_i, m_pc + 32'd4});
        else begin m_valid = 1'b1; m_instr = imem_data_i; m_pc4 = m_pc + 32'd4; end
        m_pc = m_pc + 32'd4;
      end else if (!stall_i) begin
        m_valid = 1'b0; m_instr = BUBBLE_WORD;
      end
    end
  end

  initial forever begin
    @(negedge clk_i);
    if (!rst_i && m_ready) begin
      check("pc", pc_o, m_pc);
      check("req", 32'(imem_req_o), 32'(!m_boot && skid.size() == 0));
      if (!m_boot && skid.size() == 0) check("addr", imem_addr_o, m_kill ? m_kaddr : m_pc);
      check("valid", 32'(ifid_valid_o), 32'(m_valid));
      check("instr", ifid_instr_o, m_instr);
      if (m_valid) check("pc4", ifid_pc4_o, m_pc4);
    end
  end

  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  logic found;

  initial begin
    t_field = 26'h000_0003; t_pc4 = 32'h0000_0008;
    #1 check("tgt_beq", t_br, 32'h0000_0014);
    t_field = 26'h000_0040; t_pc4 = 32'h1000_0010;
    #1 check("tgt_j", t_j, 32'h1000_0100);
    t_field = 26'h000_FFFF; t_pc4 = 32'h0000_0000;
    #1 check("tgt_wrap", t_br, 32'hFFFF_FFFC);

    mem[32'h0] = 32'h8C01_0004;
    mem[32'h4] = 32'h0000_0000;
    mem[32'h8] = 32'h2108_0001;
    repeat (2) @(posedge clk_i);
    #2 rst_i = 1'b0;
    check("rst_valid", 32'(ifid_valid_o), 32'd0);

    step();
    check("first_req", 32'(imem_req_o), 32'd1);
    check("first_addr", imem_addr_o, 32'h0);
    step(); step();
    check("w0_valid", 32'(ifid_valid_o), 32'd1);
    check("w0_instr", ifid_instr_o, 32'h8C01_0004);
    check("w0_pc4", ifid_pc4_o, 32'h4);
    step(); step();
    check("w1_instr", ifid_instr_o, 32'h0000_0000);
    check("w1_pc4", ifid_pc4_o, 32'h8);
    check("w1_pc", pc_o, 32'h8);

    stall_i = 1'b1;
    step(); step();
    check("stall_req", 32'(imem_req_o), 32'd0);
    check("stall_hold_pc4", ifid_pc4_o, 32'h8);
    check("stall_pc", pc_o, 32'hC);
    step();
    stall_i = 1'b0;
    step();
    check("skid_instr", ifid_instr_o, 32'h2108_0001);
    check("skid_pc4", ifid_pc4_o, 32'hC);
    check("skid_next_addr", imem_addr_o, 32'hC);

    rst_i = 1'b1;
    step(); step();
    mem[32'h0]   = 32'h2402_0001;
    mem[32'h4]   = 32'h1000_0003;
    mem[32'h8]   = 32'hDEAD_0008;
    mem[32'h14]  = 32'h0800_0040;
    mem[32'h18]  = 32'hDEAD_0018;
    mem[32'h100] = 32'h2463_0005;
    rst_i = 1'b0;

    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (ifid_valid_o && ifid_pc4_o == 32'h8) found = 1'b1;
    end
    check("wait_beq", 32'(found), 32'd1);
    check("beq_instr", ifid_instr_o, 32'h1000_0003);
    stall_i = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (imem_ack_i) found = 1'b1;
      else step();
    end
    check("wait_ack", 32'(found), 32'd1);
    branch_i = 1'b1;
    step();
    branch_i = 1'b0;
    stall_i = 1'b0;
    lat = 3;
    check("br_pc", pc_o, 32'h14);
    check("br_flush", ifid_instr_o, BUBBLE_WORD);
    check("br_addr", imem_addr_o, 32'h14);

    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (ifid_valid_o && ifid_pc4_o == 32'h18) found = 1'b1;
    end
    check("wait_j", 32'(found), 32'd1);
    check("j_instr", ifid_instr_o, 32'h0800_0040);
    branch_i = 1'b1;
    jump_i = 1'b1;
    step();
    branch_i = 1'b0;
    jump_i = 1'b0;
    check("kill_pc", pc_o, 32'h100);
    check("kill_req", 32'(imem_req_o), 32'd1);
    check("kill_addr", imem_addr_o, 32'h18);
    check("kill_valid", 32'(ifid_valid_o), 32'd0);

    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      if (ifid_valid_o) found = 1'b1;
    end
    check("wait_tgt", 32'(found), 32'd1);
    check("tgt_instr", ifid_instr_o, 32'h2463_0005);
    check("tgt_pc4", ifid_pc4_o, 32'h104);

    step();
    #3 rst_i = 1'b1;
    #1;
    check("mid_rst_req", 32'(imem_req_o), 32'd0);
    check("mid_rst_valid", 32'(ifid_valid_o), 32'd0);
    check("mid_rst_instr", ifid_instr_o, BUBBLE_WORD);
    check("mid_rst_pc4", ifid_pc4_o, 32'h0);
    check("mid_rst_pc", pc_o, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Producer side of the opcode/control decode path.
- Owns the PC and issues instruction-memory requests over a variable-latency req/ack handshake.
- Presents fetched words to the decode stage through the IF/ID register.
- Applies branch/jump redirects from decode, plus stalls from the hazard unit.
- A bubble is instruction 0x00000000 (opcode 000000, sll $0, a harmless R-type).

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded at reset.
- BUBBLE, 32'h0000_0000: instruction word driven when the IF/ID slot is empty or flushed.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- imem_req_o  out  1  request valid; held until ack.
- imem_addr_o  out  32  word address (bits [1:0] always 00); stable while req high.
- imem_ack_i  in  1  response valid; one cycle per request, at least 1 cycle after req rises.
- imem_data_i  in  32  instruction word, valid with ack.
- stall_i  in  1  hazard-unit freeze of IF/ID and PC.
- branch_i  in  1  taken branch for the instruction in IF/ID (beq resolved equal).
- jump_i  in  1  j instruction in IF/ID.
- ifid_valid_o  out  1  IF/ID holds a real instruction.
- ifid_instr_o  out  32  instruction to the decoder; BUBBLE when invalid.
- ifid_pc4_o  out  32  PC+4 of that instruction.
- pc_o  out  32  current fetch PC.

Behaviour:
- Reset (asynchronous): pc=RESET_PC, state=S_BOOT, imem_req_o=0, ifid_valid_o=0, ifid_instr_o=BUBBLE, ifid_pc4_o=0, skid empty.
- States:
  - S_BOOT: req low for one cycle, then S_REQ.
  - S_REQ: req=1, addr=pc.
  - S_KILL: req=1 with the old address held until ack; the response is discarded, then S_REQ.
  - S_WAIT: response parked in the skid, req=0.
- Accept in S_REQ: imem_ack_i while no redirect.
  - stall_i=0: IF/ID <= {1, imem_data_i, pc+4}, pc <= pc+4, stay in S_REQ (next request the following cycle).
  - stall_i=1: word and pc+4 go to a one-entry skid, pc <= pc+4, go to S_WAIT.
- S_WAIT: on the first cycle with stall_i=0, skid -> IF/ID, skid cleared, go to S_REQ.
- No ack and stall_i=0: IF/ID <= bubble (valid=0).
- stall_i=1: IF/ID holds.
- Redirect = (branch_i | jump_i) & ifid_valid_o. It is taken regardless of stall_i and has priority over stall and accept.
  - Branch target = ifid_pc4 + {sext(ifid_instr[15:0]), 2'b00}, 32-bit wrap.
  - Jump target = {ifid_pc4[31:28], ifid_instr[25:0], 2'b00}.
  - If both are asserted, jump wins.
  - On redirect: pc <= target, IF/ID flushed to bubble, skid cleared.
  - Next state is S_KILL if a request is outstanding without ack this cycle; otherwise S_REQ. This includes an ack in the same cycle, whose data is dropped.
  - branch_i/jump_i are ignored when ifid_valid_o=0.
- Latency: first instruction is valid in IF/ID 2 cycles after reset release plus memory latency. Steady state with 1-cycle ack: one instruction every 2 cycles.
- PC arithmetic is 32-bit and wraps 0xFFFF_FFFC -> 0x0000_0000.
- Reset mid-request: the request is abandoned immediately; no kill handling is required; the memory side is reset by the same rst_i.

Optional Feature:
- Macro IF_DELAY_SLOT_EN.
- Defined (MIPS delay-slot semantics):
  - A redirect does not flush the instruction already accepted behind the branch/jump. That is the word arriving with ack in the redirect cycle, or the word in the skid.
  - That word is delivered to IF/ID.
  - A request still outstanding is fetched, not killed, and its word is delivered.
  - The PC then loads the target.
- Undefined: flush behaviour as above.

Decomposition:
- Shared package:
  - state encoding constants S_BOOT/S_REQ/S_KILL/S_WAIT;
  - opcode constants OP_RTYPE=000000, OP_J=000010, OP_BEQ=000100;
  - BUBBLE word;
  - instruction field slice constants (IMM16, TARGET26).
- One natural sub-module, instr_fetch_target: combinational branch/jump target computation from ifid_instr and ifid_pc4.
- PC, FSM, skid and IF/ID stay in the top.

Test Plan:
- Reset release, imem ack 1 cycle after each req, mem[0]=0x8C01_0004, mem[4]=0x0000_0000 -> addr 0x0 then 0x4; IF/ID shows 0x8C01_0004/pc4=0x4, then 0x0000_0000/pc4=0x8.
- stall_i=1 for 3 cycles while ack arrives -> IF/ID held, word in skid, req low; after stall drops, IF/ID gets the skid word, next req addr = pc+4.
- IF/ID holds beq 0x1000_0003 at pc4=0x8, branch_i=1 -> pc=0x14, IF/ID=bubble, next imem_addr_o=0x14.
- IF/ID holds j 0x0800_0040, pc4=0x1000_0010 -> target 0x1000_0100.
- Redirect with a request outstanding (ack 3 cycles later) -> S_KILL, old address held, returned word dropped, then req addr=target. With IF_DELAY_SLOT_EN, that word appears in IF/ID before the target.
- branch_i and jump_i together with a valid jump word -> jump target used. rst_i pulsed mid-request -> all outputs at reset values in the same cycle.
